// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter and broadcaster for the execute stage.
// Grants at most one functional unit per cycle (yumi), registers the winning
// packet onto the CDB one cycle later.
// Build option: define CDB_RR_EN for round-robin arbitration; when it is
// undefined the arbiter uses fixed priority (lowest index wins).

package cdb_pkg;
    typedef struct packed {
        logic        load_step1;
        logic [3:0]  dest_ROB_entry;
        logic [31:0] result;
        logic        branch_result;
        logic        from_memory;
    } CDB_packet_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned PTR_W  = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_FU-1:0] fu_valid,
    input  CDB_packet_t       fu_pkt [NUM_FU],
    input  logic              flush,
    output logic [NUM_FU-1:0] fu_yumi,
    output logic              cdb_valid,
    output CDB_packet_t       cdb_out
);

    logic             grant;
    logic [PTR_W-1:0] winner;

`ifdef CDB_RR_EN
    logic [PTR_W-1:0] rr_ptr;

    // Round-robin search starting at rr_ptr, wrapping explicitly at NUM_FU
    always_comb begin
        int unsigned idx;
        grant  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!grant && fu_valid[idx[PTR_W-1:0]]) begin
                grant  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
        // Flush and reset suppress any grant
        if (flush || !reset) grant = 1'b0;
    end

    // Advance pointer past the winner on a grant; wrap at NUM_FU, not 2**PTR_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (winner == PTR_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;
        end
    end
`else
    // Fixed priority: lowest valid index wins
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (!grant && fu_valid[i[PTR_W-1:0]]) begin
                grant  = 1'b1;
                winner = i[PTR_W-1:0];
            end
        end
        // Flush and reset suppress any grant
        if (flush || !reset) grant = 1'b0;
    end
`endif

    // One-hot-or-zero yumi back to the winning unit
    always_comb begin
        fu_yumi = '0;
        if (grant) fu_yumi[winner] = 1'b1;
    end

    // Broadcast register: capture winner's packet, hold payload when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid <= 1'b0;
            cdb_out   <= '0;
        end else begin
            cdb_valid <= grant;
            if (grant) cdb_out <= fu_pkt[winner];
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (NUM_FU=4).
// Expected values follow the arbitration mode selected by CDB_RR_EN.

module tb_cdb_arbiter;
    import cdb_pkg::*;

`ifdef CDB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  fu_valid;
    CDB_packet_t pkt [4];
    logic        flush;
    logic [3:0]  fu_yumi;
    logic        cdb_valid;
    CDB_packet_t cdb_out;

    int n_cmp;
    int n_bad;

    cdb_arbiter #(.NUM_FU(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .fu_valid (fu_valid),
        .fu_pkt   (pkt),
        .flush    (flush),
        .fu_yumi  (fu_yumi),
        .cdb_valid(cdb_valid),
        .cdb_out  (cdb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] p64(input CDB_packet_t p);
        return {25'b0, p};
    endfunction

    initial begin
        logic [3:0]  exp_y;
        CDB_packet_t last;
        int          w;
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        fu_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            pkt[i].load_step1     = 1'b0;
            pkt[i].dest_ROB_entry = 4'(i + 8);
            pkt[i].result         = 32'h1000_0000 + 32'(i);
            pkt[i].branch_result  = 1'b0;
            pkt[i].from_memory    = (i == 2);
        end

        // Reset held with all units requesting
        tick(); tick(); tick();
        check("rst_yumi",  {60'b0, fu_yumi}, 64'h0);
        check("rst_valid", {63'b0, cdb_valid}, 64'h0);
        check("rst_out",   p64(cdb_out), 64'h0);

        // Release reset, then 8 cycles of full contention
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            w     = RR ? (i % 4) : 0;
            exp_y = 4'b0001 << w;
            check($sformatf("cont_yumi%0d", i), {60'b0, fu_yumi}, {60'b0, exp_y});
            tick();
            check($sformatf("cont_valid%0d", i), {63'b0, cdb_valid}, 64'h1);
            check($sformatf("cont_out%0d", i), p64(cdb_out), p64(pkt[w]));
        end
        last = RR ? pkt[3] : pkt[0];

        // Idle: no grant, payload holds
        fu_valid = 4'b0000;
        #1;
        check("idle_yumi", {60'b0, fu_yumi}, 64'h0);
        tick();
        check("idle_valid", {63'b0, cdb_valid}, 64'h0);
        check("idle_hold",  p64(cdb_out), p64(last));

        // Single request from FU2
        pkt[2].result         = 32'hDEADBEEF;
        pkt[2].dest_ROB_entry = 4'h5;
        fu_valid = 4'b0100;
        #1;
        check("single_yumi", {60'b0, fu_yumi}, 64'h4);
        tick();
        check("single_valid", {63'b0, cdb_valid}, 64'h1);
        check("single_res",   {32'b0, cdb_out.result}, 64'hDEADBEEF);
        check("single_dest",  {60'b0, cdb_out.dest_ROB_entry}, 64'h5);

        // Flush kills grant; FU1 granted once flush drops (pointer was 3)
        fu_valid = 4'b0010;
        flush    = 1'b1;
        #1;
        check("flush_yumi", {60'b0, fu_yumi}, 64'h0);
        tick();
        check("flush_valid", {63'b0, cdb_valid}, 64'h0);
        flush = 1'b0;
        #1;
        check("postflush_yumi", {60'b0, fu_yumi}, 64'h2);
        tick();
        check("postflush_valid", {63'b0, cdb_valid}, 64'h1);
        check("postflush_out",   p64(cdb_out), p64(pkt[1]));

        // Move pointer to 3 by granting FU2
        fu_valid = 4'b0100;
        #1;
        check("pre_wrap_yumi", {60'b0, fu_yumi}, 64'h4);
        tick();

        // Wrap: FU3 and FU0 valid, FU3 carries flag bits
        pkt[3].branch_result = 1'b1;
        pkt[3].load_step1    = 1'b1;
        pkt[3].result        = 32'hA5C3_0F01;
        fu_valid = 4'b1001;
        w = RR ? 3 : 0;
        #1;
        check("wrap_yumi", {60'b0, fu_yumi}, RR ? 64'h8 : 64'h1);
        tick();
        check("wrap_valid", {63'b0, cdb_valid}, 64'h1);
        check("wrap_out",   p64(cdb_out), p64(pkt[w]));
        #1;
        check("wrap_next_yumi", {60'b0, fu_yumi}, 64'h1);
        tick();
        check("wrap_next_out", p64(cdb_out), p64(pkt[0]));

        // Asynchronous reset mid-cycle; arbitration restarts at index 0
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", {63'b0, cdb_valid}, 64'h0);
        check("areset_out",   p64(cdb_out), 64'h0);
        check("areset_yumi",  {60'b0, fu_yumi}, 64'h0);
        tick();
        check("areset_hold_valid", {63'b0, cdb_valid}, 64'h0);
        reset = 1'b1;
        #1;
        check("rerelease_yumi", {60'b0, fu_yumi}, 64'h1);
        tick();
        check("rerelease_out", p64(cdb_out), p64(pkt[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
